calc_error_ctrl: RTL

//  Parametrised result-write gate and error status unit for the calculator datapath.

---
 rtl/calc_error_ctrl_if.sv | 30 +++
 rtl/calc_error_ctrl.sv | 129 ++++++++++++
 2 files changed

// File: rtl/calc_error_ctrl_if.sv
// Request/status bundle between the calculator sequencer and calc_error_ctrl.
// master drives calc strobes and acks; slave (calc_error_ctrl) returns write gate and error status.
interface calc_error_ctrl_if #(
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 8,
  parameter int HIST_D  = 4
);
  localparam int CODE_W = $clog2(NUM_SRC + 1);

  logic                     calc_pulse;
  logic [NUM_SRC-1:0]       err_in;
  logic                     clear_err;
  logic                     cnt_clr;
  logic                     accept_write;
  logic                     error_flag;
  logic [CODE_W-1:0]        err_code;
  logic [NUM_SRC-1:0]       err_vec;
  logic [CNT_W-1:0]         err_count;
  logic [HIST_D*CODE_W-1:0] err_hist;

  modport master (
    output calc_pulse, err_in, clear_err, cnt_clr,
    input  accept_write, error_flag, err_code, err_vec, err_count, err_hist
  );

  modport slave (
    input  calc_pulse, err_in, clear_err, cnt_clr,
    output accept_write, error_flag, err_code, err_vec, err_count, err_hist
  );
endinterface

// File: rtl/calc_error_ctrl.sv
// Result-write gate and error status unit; 1-clk registered response to calc_pulse.
// Optional error-code history is built only when CALC_ERR_HIST_EN is defined.
module calc_error_ctrl #(
  parameter int NUM_SRC = 2,
  parameter int STICKY  = 0,
  parameter int CNT_W   = 8,
  parameter int HIST_D  = 4
) (
  input logic              clk,
  input logic              rst_n,
  calc_error_ctrl_if.slave bus
);
  localparam int CODE_W = $clog2(NUM_SRC + 1);
  localparam int HIST_W = HIST_D * CODE_W;

  typedef enum logic {S_OK = 1'b0, S_ERR = 1'b1} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_accept;
  logic               w_accept_nxt;
  logic               r_flag;
  logic               w_flag_nxt;
  logic [CODE_W-1:0]  r_code;
  logic [CODE_W-1:0]  w_code_nxt;
  logic [NUM_SRC-1:0] r_vec;
  logic [NUM_SRC-1:0] w_vec_nxt;
  logic [CNT_W-1:0]   r_count;
  logic [CODE_W-1:0]  w_code;
  logic               w_any_err;
  logic               w_err_event;
  logic               w_released;

  assign w_any_err   = |bus.err_in;
  assign w_err_event = bus.calc_pulse && w_any_err;
  // An ack in S_ERR releases the error before the same-cycle calc is judged
  assign w_released  = (r_state == S_OK) || bus.clear_err;

  // Lowest set bit wins: scan downwards so the last hit is the lowest index
  always_comb begin
    w_code = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (bus.err_in[i]) w_code = CODE_W'(i + 1);
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_accept_nxt = 1'b0;
    w_flag_nxt   = r_flag;
    w_code_nxt   = r_code;
    w_vec_nxt    = r_vec;

    if (r_state == S_ERR && bus.clear_err) begin
      w_state_nxt = S_OK;
      w_flag_nxt  = 1'b0;
      w_code_nxt  = '0;
      w_vec_nxt   = '0;
    end

    if (bus.calc_pulse) begin
      if (w_released) begin
        if (w_any_err) begin
          w_state_nxt = S_ERR;
          w_flag_nxt  = 1'b1;
          w_code_nxt  = w_code;
          w_vec_nxt   = bus.err_in;
        end else begin
          w_accept_nxt = 1'b1;
        end
      end else if (STICKY == 0) begin
        if (w_any_err) begin
          w_code_nxt = w_code;
          w_vec_nxt  = bus.err_in;
        end else begin
          w_state_nxt  = S_OK;
          w_flag_nxt   = 1'b0;
          w_code_nxt   = '0;
          w_vec_nxt    = '0;
          w_accept_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_OK;
      r_accept <= 1'b0;
      r_flag   <= 1'b0;
      r_code   <= '0;
      r_vec    <= '0;
      r_count  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_accept <= w_accept_nxt;
      r_flag   <= w_flag_nxt;
      r_code   <= w_code_nxt;
      r_vec    <= w_vec_nxt;
      if (bus.cnt_clr) begin
        r_count <= '0;
      end else if (w_err_event && !(&r_count)) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

`ifdef CALC_ERR_HIST_EN
  logic [HIST_W-1:0] r_hist;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hist <= '0;
    end else if (w_err_event) begin
      r_hist <= (r_hist << CODE_W) | HIST_W'(w_code);
    end
  end

  assign bus.err_hist = r_hist;
`else
  assign bus.err_hist = '0;
`endif

  assign bus.accept_write = r_accept;
  assign bus.error_flag   = r_flag;
  assign bus.err_code     = r_code;
  assign bus.err_vec      = r_vec;
  assign bus.err_count    = r_count;
endmodule
